mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Port A is a read-only fetch port; port B is a load/store data port.
module mem_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_wmask,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  // last_b_q set means B won most recently, so A wins the next tie.
  logic        last_b_q, last_b_d;
  logic        tag_valid_q, tag_valid_d;
  logic        tag_b_q, tag_b_d;
  logic [31:0] a_rdata_q, b_rdata_q;
  logic        grant_a, grant_b;
  logic        b_write;

  assign b_write = (b_wmask != 4'b0000);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (resetn) begin
      if (a_req && b_req) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  always_comb begin
    mem_addr  = grant_b ? b_addr : a_addr;
    mem_wdata = b_wdata;
    mem_rd_en = grant_a || (grant_b && !b_write);
    mem_wmask = grant_b ? b_wmask : 4'b0000;
  end

  always_comb begin
    last_b_d = last_b_q;
    if (grant_a) begin
      last_b_d = 1'b0;
    end else if (grant_b) begin
      last_b_d = 1'b1;
    end
    tag_valid_d = mem_rd_en;
    tag_b_d     = grant_b;
  end

  // Gating with resetn drops a response whose reset lands in its delivery cycle.
  assign a_rvalid = resetn && tag_valid_q && !tag_b_q;
  assign b_rvalid = resetn && tag_valid_q && tag_b_q;

  assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
  assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_b_q    <= 1'b1;
      tag_valid_q <= 1'b0;
      tag_b_q     <= 1'b0;
      a_rdata_q   <= 32'h0;
      b_rdata_q   <= 32'h0;
    end else begin
      last_b_q    <= last_b_d;
      tag_valid_q <= tag_valid_d;
      tag_b_q     <= tag_b_d;
      if (a_rvalid) begin
        a_rdata_q <= mem_rdata;
      end
      if (b_rvalid) begin
        b_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM and a
// response scoreboard fed from a bench-side reference memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        a_req = 1'b0;
  logic [31:0] a_addr = 32'h0;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0;
  logic [31:0] b_addr = 32'h0;
  logic [31:0] b_wdata = 32'h0;
  logic [3:0]  b_wmask = 4'h0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd_en;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit          port_b;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t exp;

  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];

  mem_arbiter dut (
    .clk      (clk),
    .resetn   (resetn),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_wmask  (b_wmask),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr[9:2]];
    for (int i = 0; i < 4; i++) begin
      if (mem_wmask[i]) ram[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) ref_mem[addr[9:2]][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    a_req  = 1'b1;
    b_req  = 1'b1;
    a_addr = 32'h4;
    b_addr = 32'h8;
    tick();
    tick();
    #1;
    tests_run++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_gnt: a_gnt=%b b_gnt=%b, required 0 0", a_gnt, b_gnt);
    end
    tests_run++;
    if (mem_rd_en !== 1'b0 || mem_wmask !== 4'h0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outs: rd_en=%b wmask=%h a_rv=%b b_rv=%b, required all 0",
               mem_rd_en, mem_wmask, a_rvalid, b_rvalid);
    end
    tests_run++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: a_rdata=%h b_rdata=%h, required 0", a_rdata, b_rdata);
    end
    a_req  = 1'b0;
    b_req  = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_a_only();
    a_req  = 1'b1;
    a_addr = 32'h4;
    #1;
    tests_run++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 32'h4 ||
        mem_wmask !== 4'h0) begin
      tests_failed++;
      $display("FAIL a_only_cmd: a_gnt=%b b_gnt=%b rd_en=%b addr=%h wmask=%h, required 1 0 1 4 0",
               a_gnt, b_gnt, mem_rd_en, mem_addr, mem_wmask);
    end
    exp_q.push_back('{port_b: 1'b0, data: ref_mem[1]});
    tick();
    a_req = 1'b0;
    #1;
    exp = exp_q.pop_front();
    tests_run++;
    if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== exp.data ||
        a_rdata !== 32'h00A08093) begin
      tests_failed++;
      $display("FAIL a_only_rsp: a_rv=%b b_rv=%b a_rdata=%h, required 1 0 %h",
               a_rvalid, b_rvalid, a_rdata, exp.data);
    end
    tick();
    #1;
    tests_run++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h00A08093) begin
      tests_failed++;
      $display("FAIL a_only_hold: a_rv=%b a_rdata=%h, required 0 00a08093", a_rvalid, a_rdata);
    end
  endtask

  task automatic b_write_op(input string name, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] mask);
    b_req   = 1'b1;
    b_addr  = addr;
    b_wdata = data;
    b_wmask = mask;
    #1;
    tests_run++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_rd_en !== 1'b0 || mem_wmask !== mask ||
        mem_addr !== addr || mem_wdata !== data) begin
      tests_failed++;
      $display("FAIL %s_cmd: b_gnt=%b rd_en=%b wmask=%h addr=%h wdata=%h, required 1 0 %h %h %h",
               name, b_gnt, mem_rd_en, mem_wmask, mem_addr, mem_wdata, mask, addr, data);
    end
    ref_write(addr, data, mask);
    tick();
    b_req   = 1'b0;
    b_wmask = 4'h0;
    #1;
    tests_run++;
    if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_norv: b_rv=%b a_rv=%b, required 0 0", name, b_rvalid, a_rvalid);
    end
  endtask

  task automatic b_read_op(input string name, input logic [31:0] addr,
                           input logic [31:0] want);
    b_req   = 1'b1;
    b_addr  = addr;
    b_wmask = 4'h0;
    #1;
    tests_run++;
    if (b_gnt !== 1'b1 || mem_rd_en !== 1'b1 || mem_wmask !== 4'h0 || mem_addr !== addr) begin
      tests_failed++;
      $display("FAIL %s_cmd: b_gnt=%b rd_en=%b wmask=%h addr=%h, required 1 1 0 %h",
               name, b_gnt, mem_rd_en, mem_wmask, mem_addr, addr);
    end
    exp_q.push_back('{port_b: 1'b1, data: ref_mem[addr[9:2]]});
    tick();
    b_req = 1'b0;
    #1;
    exp = exp_q.pop_front();
    tests_run++;
    if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || b_rdata !== exp.data || b_rdata !== want) begin
      tests_failed++;
      $display("FAIL %s_rsp: b_rv=%b a_rv=%b b_rdata=%h, required 1 0 %h (const %h)",
               name, b_rvalid, a_rvalid, b_rdata, exp.data, want);
    end
  endtask

  task automatic test_b_write_read();
    b_write_op("b_write", 32'h190, 32'h0000000A, 4'b1111);
    b_read_op("b_read", 32'h190, 32'h0000000A);
  endtask

  task automatic test_byte_write();
    b_write_op("word_init", 32'h190, 32'h04030201, 4'b1111);
    b_write_op("byte_write", 32'h191, 32'h0000FF00, 4'b0010);
    b_read_op("byte_read", 32'h190, 32'h0403FF01);
  endtask

  task automatic test_back_to_back();
    bit exp_a;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    a_req  = 1'b1;
    b_req  = 1'b1;
    a_addr = 32'h4;
    b_addr = 32'h190;
    b_wmask = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (a_rvalid !== !exp.port_b || b_rvalid !== exp.port_b ||
            (exp.port_b ? b_rdata : a_rdata) !== exp.data) begin
          tests_failed++;
          $display("FAIL rr_rsp%0d: a_rv=%b b_rv=%b a_rdata=%h b_rdata=%h, required port_b=%b data=%h",
                   i, a_rvalid, b_rvalid, a_rdata, b_rdata, exp.port_b, exp.data);
        end
      end
      if (i < 4) begin
        exp_a = (i % 2 == 0);
        tests_run++;
        if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
          tests_failed++;
          $display("FAIL rr_gnt%0d: a_gnt=%b b_gnt=%b, required %b %b",
                   i, a_gnt, b_gnt, exp_a, !exp_a);
        end
        exp_q.push_back('{port_b: !exp_a, data: exp_a ? ref_mem[1] : ref_mem[100]});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    a_req  = 1'b1;
    a_addr = 32'h4;
    #1;
    tests_run++;
    if (a_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_gnt: a_gnt=%b, required 1", a_gnt);
    end
    tick();
    resetn = 1'b0;
    a_req  = 1'b0;
    #1;
    tests_run++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_rv0: a_rv=%b b_rv=%b, required 0 0", a_rvalid, b_rvalid);
    end
    tick();
    #1;
    tests_run++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_rv1: a_rv=%b a_rdata=%h, required 0 0", a_rvalid, a_rdata);
    end
    resetn = 1'b1;
    a_req  = 1'b1;
    b_req  = 1'b1;
    b_addr = 32'h190;
    #1;
    tests_run++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_prio: a_gnt=%b b_gnt=%b, required 1 0", a_gnt, b_gnt);
    end
    tick();
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (mem_rd_en !== 1'b0 || mem_wmask !== 4'h0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 ||
          a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle%0d: rd_en=%b wmask=%h a_rv=%b b_rv=%b gnt=%b%b, required all 0",
                 i, mem_rd_en, mem_wmask, a_rvalid, b_rvalid, a_gnt, b_gnt);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram[1]       = 32'h00A08093;
    ref_mem[1]   = 32'h00A08093;
    ram[100]     = 32'h04030201;
    ref_mem[100] = 32'h04030201;
    @(negedge clk);
    test_reset();
    test_a_only();
    test_b_write_read();
    test_byte_write();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
